// File: rtl/mem_arbiter.sv
// ============================================================================
//  Module      : mem_arbiter
//  Description : Single-port shared RAM arbiter for downloader, eraser, video
//                fetch and CPU, with one access in flight at a time.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module mem_arbiter #(
    parameter int              ADDR_W   = 18,
    parameter logic [ADDR_W-1:0] PRG_BASE = 18'h08995
) (
    input  logic              clk,
    input  logic              reset_n,

    input  logic              dl_req,
    input  logic [7:0]        dl_index,
    input  logic [24:0]       dl_addr,
    input  logic [7:0]        dl_data,
    output logic              dl_ack,

    input  logic              er_req,
    input  logic [24:0]       er_addr,
    input  logic [7:0]        er_data,
    output logic              er_ack,

    input  logic              vid_req,
    input  logic [ADDR_W-1:0] vid_addr,
    output logic              vid_ack,

    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [7:0]        cpu_wdata,
    output logic              cpu_ack,
    output logic              cpu_wait,

    output logic [7:0]        rdata,

    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_din,
    output logic              mem_wr,
    output logic              mem_en,
    input  logic [7:0]        mem_q,

    output logic              cpu_blank
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RDWAIT = 2'd2
    } state_t;

    localparam logic [1:0] c_own_dl  = 2'd0;
    localparam logic [1:0] c_own_er  = 2'd1;
    localparam logic [1:0] c_own_vid = 2'd2;
    localparam logic [1:0] c_own_cpu = 2'd3;

    state_t              state_q,     state_d;
    logic [1:0]          owner_q,     owner_d;
    logic [ADDR_W-1:0]   addr_q,      addr_d;
    logic [7:0]          din_q,       din_d;
    logic                we_q,        we_d;
    logic                rd_q,        rd_d;
    logic                last_vid_q,  last_vid_d;
    logic [3:0]          ack_q,       ack_d;
    logic [7:0]          rdata_q,     rdata_d;

    logic [3:0]          req_v;
    logic                unused_addr_bits;

    // A requester whose ack is visible this cycle must drop its req before
    // it can be granted again; otherwise a held req would be re-served.
    assign req_v = {cpu_req, vid_req, er_req, dl_req} & ~ack_q;

    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        addr_d     = addr_q;
        din_d      = din_q;
        we_d       = we_q;
        rd_d       = rd_q;
        last_vid_d = last_vid_q;
        ack_d      = 4'b0000;
        rdata_d    = rdata_q;

        case (state_q)
            ST_IDLE: begin
                if (req_v[c_own_dl]) begin
                    state_d          = ST_ACCESS;
                    owner_d          = c_own_dl;
                    rd_d             = 1'b0;
                    we_d             = (dl_index == 8'd0) || (dl_index == 8'd1);
                    din_d            = dl_data;
                    addr_d           = (dl_index == 8'd1) ? (dl_addr[ADDR_W-1:0] + PRG_BASE)
                                                          : dl_addr[ADDR_W-1:0];
                    ack_d[c_own_dl]  = 1'b1;
                end else if (req_v[c_own_er]) begin
                    state_d          = ST_ACCESS;
                    owner_d          = c_own_er;
                    rd_d             = 1'b0;
                    we_d             = 1'b1;
                    din_d            = er_data;
                    addr_d           = er_addr[ADDR_W-1:0];
                    ack_d[c_own_er]  = 1'b1;
                end else if (req_v[c_own_vid] && (!req_v[c_own_cpu] || !last_vid_q)) begin
                    state_d          = ST_ACCESS;
                    owner_d          = c_own_vid;
                    rd_d             = 1'b1;
                    we_d             = 1'b0;
                    addr_d           = vid_addr;
                    last_vid_d       = 1'b1;
                end else if (req_v[c_own_cpu]) begin
                    state_d          = ST_ACCESS;
                    owner_d          = c_own_cpu;
                    rd_d             = ~cpu_we;
                    we_d             = cpu_we;
                    din_d            = cpu_wdata;
                    addr_d           = cpu_addr;
                    last_vid_d       = 1'b0;
                    ack_d[c_own_cpu] = cpu_we;
                end
            end
            ST_ACCESS: begin
                state_d = rd_q ? ST_RDWAIT : ST_IDLE;
            end
            ST_RDWAIT: begin
                rdata_d        = mem_q;
                ack_d[owner_q] = 1'b1;
                state_d        = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            owner_q    <= c_own_dl;
            addr_q     <= '0;
            din_q      <= 8'h00;
            we_q       <= 1'b0;
            rd_q       <= 1'b0;
            last_vid_q <= 1'b0;
            ack_q      <= 4'b0000;
            rdata_q    <= 8'h00;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            addr_q     <= addr_d;
            din_q      <= din_d;
            we_q       <= we_d;
            rd_q       <= rd_d;
            last_vid_q <= last_vid_d;
            ack_q      <= ack_d;
            rdata_q    <= rdata_d;
        end
    end

    assign dl_ack    = ack_q[c_own_dl];
    assign er_ack    = ack_q[c_own_er];
    assign vid_ack   = ack_q[c_own_vid];
    assign cpu_ack   = ack_q[c_own_cpu];
    assign cpu_wait  = cpu_req & ~cpu_ack;
    assign rdata     = rdata_q;

    assign mem_addr  = addr_q;
    assign mem_din   = din_q;
    assign mem_en    = (state_q == ST_ACCESS);
    assign mem_wr    = (state_q == ST_ACCESS) & we_q;

    // Downloader/eraser traffic (pending or in flight) keeps the CPU parked.
    assign cpu_blank = dl_req | er_req | ((state_q != ST_IDLE) & ~owner_q[1]);

    assign unused_addr_bits = ^{dl_addr[24:ADDR_W], er_addr[24:ADDR_W]};

endmodule

`default_nettype wire

// File: tb/tb_mem_arbiter.sv
// ============================================================================
//  Module      : tb_mem_arbiter
//  Description : Directed self-checking bench for mem_arbiter with a 1-cycle
//                latency RAM model on port A.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        dl_req, er_req, vid_req, cpu_req, cpu_we;
    logic [7:0]  dl_index, dl_data, er_data, cpu_wdata;
    logic [24:0] dl_addr, er_addr;
    logic [17:0] vid_addr, cpu_addr;
    logic        dl_ack, er_ack, vid_ack, cpu_ack, cpu_wait, cpu_blank;
    logic [7:0]  rdata, mem_din, mem_q;
    logic [17:0] mem_addr;
    logic        mem_wr, mem_en;

    logic [7:0]  ram [0:(1<<18)-1];

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_en && mem_wr) ram[mem_addr] <= mem_din;
        mem_q <= ram[mem_addr];
    end

    mem_arbiter #(.ADDR_W(18), .PRG_BASE(18'h08995)) dut (
        .clk(clk), .reset_n(reset_n),
        .dl_req(dl_req), .dl_index(dl_index), .dl_addr(dl_addr), .dl_data(dl_data), .dl_ack(dl_ack),
        .er_req(er_req), .er_addr(er_addr), .er_data(er_data), .er_ack(er_ack),
        .vid_req(vid_req), .vid_addr(vid_addr), .vid_ack(vid_ack),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_ack(cpu_ack), .cpu_wait(cpu_wait),
        .rdata(rdata),
        .mem_addr(mem_addr), .mem_din(mem_din), .mem_wr(mem_wr), .mem_en(mem_en), .mem_q(mem_q),
        .cpu_blank(cpu_blank)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Downloader write; returns mem_addr/mem_wr/cpu_blank seen in the ack cycle.
    task automatic dl_write(input logic [7:0] idx, input logic [24:0] a, input logic [7:0] d,
                            output logic [17:0] o_addr, output logic o_wr,
                            output logic o_blank, output int lat);
        dl_req = 1'b1; dl_index = idx; dl_addr = a; dl_data = d;
        lat = 0;
        do begin next_cycle(); lat++; end while (!dl_ack && lat < 10);
        o_addr = mem_addr; o_wr = mem_wr; o_blank = cpu_blank;
        dl_req = 1'b0;
        next_cycle();
    endtask

    task automatic cpu_access(input logic we, input logic [17:0] a, input logic [7:0] wd,
                              output logic [7:0] rd, output int lat, output int waits);
        cpu_req = 1'b1; cpu_we = we; cpu_addr = a; cpu_wdata = wd;
        lat = 0; waits = 0;
        #1;
        if (cpu_wait) waits++;
        while (!cpu_ack && lat < 10) begin
            next_cycle(); lat++;
            if (cpu_wait) waits++;
        end
        rd = rdata;
        cpu_req = 1'b0;
        next_cycle();
    endtask

    task automatic vid_read(input logic [17:0] a, output logic [7:0] rd, output int lat);
        vid_req = 1'b1; vid_addr = a;
        lat = 0;
        do begin next_cycle(); lat++; end while (!vid_ack && lat < 10);
        rd = rdata;
        vid_req = 1'b0;
        next_cycle();
    endtask

    logic [17:0] o_addr;
    logic        o_wr, o_blank;
    logic [7:0]  rd;
    int          lat, waits;
    int          order [6];
    int          exp_order [6];
    int          n_ack, overlap, cyc;
    logic [3:0]  acks;

    initial begin
        reset_n = 1'b0;
        dl_req = 0; er_req = 0; vid_req = 0; cpu_req = 0; cpu_we = 0;
        dl_index = 0; dl_addr = 0; dl_data = 0; er_addr = 0; er_data = 0;
        vid_addr = 0; cpu_addr = 0; cpu_wdata = 0;
        exp_order = '{0, 1, 2, 3, 2, 3};

        // Reset state, and no grant while reset is held.
        repeat (3) next_cycle();
        check("rst_mem_en", mem_en, 0);
        check("rst_mem_wr", mem_wr, 0);
        check("rst_rdata", rdata, 0);
        check("rst_acks", {cpu_ack, vid_ack, er_ack, dl_ack}, 0);
        check("rst_blank_wait", {cpu_blank, cpu_wait}, 0);
        cpu_req = 1; cpu_we = 1; cpu_addr = 18'h00200; cpu_wdata = 8'h42;
        repeat (2) next_cycle();
        check("rst_hold_no_grant", {cpu_ack, mem_en}, 0);
        reset_n = 1'b1;
        #1;
        check("rst_release_no_ack", cpu_ack, 0);
        next_cycle();
        check("first_grant_ack", cpu_ack, 1);
        check("first_grant_addr", {mem_wr, 14'd0, mem_addr}, {1'b1, 14'd0, 18'h00200});
        cpu_req = 0;
        next_cycle();

        // Program image download with load offset, then read back via video.
        dl_write(8'd1, 25'h0000000, 8'hAA, o_addr, o_wr, o_blank, lat);
        check("dl1_addr", o_addr, 18'h08995);
        check("dl1_wr", o_wr, 1);
        check("dl1_latency", lat, 1);
        check("dl1_blank", o_blank, 1);
        check("dl1_after_wr", {mem_wr, mem_en}, 0);
        check("dl1_addr_hold", mem_addr, 18'h08995);
        vid_read(18'h08995, rd, lat);
        check("vid_rdata", rd, 8'hAA);
        check("vid_latency", lat, 3);

        // Program image offset wraps at 2^18.
        dl_write(8'd1, 25'h003F000, 8'h5A, o_addr, o_wr, o_blank, lat);
        check("dl1_wrap_addr", o_addr, 18'h07995);

        // ROM image: upper address bits dropped.
        dl_write(8'd0, 25'h0123456, 8'h77, o_addr, o_wr, o_blank, lat);
        check("dl0_addr", o_addr, 18'h23456);
        cpu_access(1'b0, 18'h23456, 8'h00, rd, lat, waits);
        check("dl0_readback", rd, 8'h77);

        // Eraser: upper bits ignored, fill byte written.
        er_req = 1; er_addr = 25'h1FC0010; er_data = 8'hE5;
        next_cycle();
        check("er_ack", er_ack, 1);
        check("er_addr_wr", {mem_wr, 6'd0, mem_addr}, {1'b1, 6'd0, 18'h00010});
        check("er_din", mem_din, 8'hE5);
        er_req = 0;
        next_cycle();

        // CPU write then read: 3 wait cycles, data returned with ack.
        cpu_access(1'b1, 18'h03000, 8'h5C, rd, lat, waits);
        check("cpu_wr_latency", lat, 1);
        cpu_access(1'b0, 18'h03000, 8'h00, rd, lat, waits);
        check("cpu_rd_waits", waits, 3);
        check("cpu_rd_latency", lat, 3);
        check("cpu_rd_data", rd, 8'h5C);

        // Unknown download slot: acked but RAM untouched.
        cpu_access(1'b1, 18'h00100, 8'h33, rd, lat, waits);
        dl_write(8'd2, 25'h0000100, 8'h11, o_addr, o_wr, o_blank, lat);
        check("dl2_ack_latency", lat, 1);
        check("dl2_no_wr", o_wr, 0);
        cpu_access(1'b0, 18'h00100, 8'h00, rd, lat, waits);
        check("dl2_ram_unchanged", rd, 8'h33);

        // All requesters at once: fixed priority, then vid/cpu alternate.
        dl_index = 1; dl_addr = 25'h10; dl_data = 8'h01;
        er_addr = 25'h20; er_data = 8'h02;
        vid_addr = 18'h00030; cpu_we = 0; cpu_addr = 18'h00040;
        dl_req = 1; er_req = 1; vid_req = 1; cpu_req = 1;
        n_ack = 0; overlap = 0; cyc = 0;
        for (int i = 0; i < 6; i++) order[i] = 9;
        while (n_ack < 6 && cyc < 60) begin
            next_cycle(); cyc++;
            acks = {cpu_ack, vid_ack, er_ack, dl_ack};
            if ($countones(acks) > 1) overlap++;
            if (dl_ack)       begin order[n_ack] = 0; n_ack++; dl_req = 0; end
            else if (er_ack)  begin order[n_ack] = 1; n_ack++; er_req = 0; end
            else if (vid_ack) begin order[n_ack] = 2; n_ack++; end
            else if (cpu_ack) begin order[n_ack] = 3; n_ack++; end
        end
        dl_req = 0; er_req = 0; vid_req = 0; cpu_req = 0;
        repeat (6) begin
            next_cycle();
            if ($countones({cpu_ack, vid_ack, er_ack, dl_ack}) > 1) overlap++;
        end
        for (int i = 0; i < 6; i++) check($sformatf("grant_order_%0d", i), order[i], exp_order[i]);
        check("ack_overlap", overlap, 0);
        check("idle_blank", cpu_blank, 0);

        // Reset while a video read sits in RDWAIT.
        cpu_access(1'b0, 18'h00100, 8'h00, rd, lat, waits);
        vid_req = 1; vid_addr = 18'h08995;
        next_cycle();
        check("abort_access_en", mem_en, 1);
        next_cycle();
        check("abort_rdwait_en", mem_en, 0);
        reset_n = 0; vid_req = 0;
        next_cycle();
        check("abort_no_ack", {cpu_ack, vid_ack, er_ack, dl_ack}, 0);
        check("abort_mem_ctl", {mem_en, mem_wr}, 0);
        check("abort_rdata", rdata, 0);
        check("abort_mem_addr_din", {6'd0, mem_addr, mem_din}, 0);
        check("abort_blank_wait", {cpu_blank, cpu_wait}, 0);
        reset_n = 1;
        repeat (4) begin
            next_cycle();
            check("abort_no_late_ack", vid_ack, 0);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
